// File: rtl/map_ram_arbiter_pkg.sv
// Shared constants for the occupancy-map RAM and its arbiter.
package map_ram_arbiter_pkg;
  localparam int GRID_W = 40;
  localparam int GRID_H = 40;
  localparam int CELL_W = 2;
  localparam int ADDR_W = 11;

  localparam logic [1:0] CELL_FREE    = 2'b00;
  localparam logic [1:0] CELL_OBST    = 2'b01;
  localparam logic [1:0] CELL_PATH    = 2'b10;
  localparam logic [1:0] CELL_UNKNOWN = 2'b11;

  typedef logic [0:0] state_t;
  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_RUN   = 1'b1;
endpackage

// File: rtl/map_ram.sv
// Single-port map storage, synchronous read with one cycle of latency.
module map_ram
  import map_ram_arbiter_pkg::*;
#(
  parameter int DEPTH = GRID_W * GRID_H,
  parameter int WIDTH = CELL_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/map_ram_arbiter.sv
// Three-requester arbiter (display > round-robin search/loader) in front of the
// map RAM, with a clear sweep that initialises every cell after reset or on request.
//   state    | meaning
//   ST_CLEAR | sweeping CLEAR_VAL into every address, no grants
//   ST_RUN   | arbitrating requests
module map_ram_arbiter
  import map_ram_arbiter_pkg::*;
#(
  parameter int                 GRID_W    = map_ram_arbiter_pkg::GRID_W,
  parameter int                 GRID_H    = map_ram_arbiter_pkg::GRID_H,
  parameter int                 CELL_W    = map_ram_arbiter_pkg::CELL_W,
  parameter logic [CELL_W-1:0]  CLEAR_VAL = 2'b00
) (
  input  logic              sync,
  input  logic              reset,
  input  logic              clear_start,
  output logic              clear_busy,
  input  logic              disp_req,
  input  logic [5:0]        disp_x,
  input  logic [5:0]        disp_y,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [CELL_W-1:0] disp_rdata,
  input  logic              srch_req,
  input  logic              srch_we,
  input  logic [5:0]        srch_x,
  input  logic [5:0]        srch_y,
  input  logic [CELL_W-1:0] srch_wdata,
  output logic              srch_gnt,
  output logic              srch_rvalid,
  output logic [CELL_W-1:0] srch_rdata,
  input  logic              load_req,
  input  logic [5:0]        load_x,
  input  logic [5:0]        load_y,
  input  logic [CELL_W-1:0] load_wdata,
  output logic              load_gnt,
  output logic              oob_err
);

  localparam int                NCELLS    = GRID_W * GRID_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NCELLS - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic                r_rr_load;
  logic                r_oob_err;
  logic                r_rd_disp;
  logic                r_rd_srch;
  logic                r_rd_oob;
  logic [CELL_W-1:0]   r_disp_hold;
  logic [CELL_W-1:0]   r_srch_hold;

  logic                w_clearing;
  logic                w_run;
  logic                w_disp_gnt;
  logic                w_srch_gnt;
  logic                w_load_gnt;
  logic                w_any_gnt;
  logic                w_acc_we;
  logic [5:0]          w_x;
  logic [5:0]          w_y;
  logic [CELL_W-1:0]   w_wdata;
  logic                w_oob;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_ram_we;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [CELL_W-1:0]   w_ram_wdata;
  logic [CELL_W-1:0]   w_ram_rdata;
  logic [CELL_W-1:0]   w_rd_val;

  assign w_clearing = (r_state == ST_CLEAR);
  // The clear_start cycle grants nothing so no read can return inside the sweep.
  assign w_run      = reset && (r_state == ST_RUN) && !clear_start;

  assign w_disp_gnt = w_run && disp_req;
  assign w_srch_gnt = w_run && !disp_req && srch_req && (!load_req || !r_rr_load);
  assign w_load_gnt = w_run && !disp_req && load_req && (!srch_req || r_rr_load);
  assign w_any_gnt  = w_disp_gnt || w_srch_gnt || w_load_gnt;

  always_comb begin
    w_x      = load_x;
    w_y      = load_y;
    w_wdata  = load_wdata;
    w_acc_we = 1'b1;
    if (w_disp_gnt) begin
      w_x      = disp_x;
      w_y      = disp_y;
      w_acc_we = 1'b0;
    end else if (w_srch_gnt) begin
      w_x      = srch_x;
      w_y      = srch_y;
      w_wdata  = srch_wdata;
      w_acc_we = srch_we;
    end
  end

  assign w_oob  = (int'(w_x) >= GRID_W) || (int'(w_y) >= GRID_H);
  assign w_addr = ADDR_W'(int'(w_y) * GRID_W + int'(w_x));

  assign w_ram_we    = w_clearing || (w_any_gnt && w_acc_we && !w_oob);
  assign w_ram_addr  = w_clearing ? r_clr_addr : (w_oob ? '0 : w_addr);
  assign w_ram_wdata = w_clearing ? CLEAR_VAL : w_wdata;

  map_ram #(
    .DEPTH (NCELLS),
    .WIDTH (CELL_W)
  ) u_map_ram (
    .i_clk   (sync),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign w_rd_val = r_rd_oob ? {CELL_W{1'b1}} : w_ram_rdata;

  always_ff @(posedge sync) begin
    if (!reset) begin
      r_state     <= ST_CLEAR;
      r_clr_addr  <= '0;
      r_rr_load   <= 1'b0;
      r_oob_err   <= 1'b0;
      r_rd_disp   <= 1'b0;
      r_rd_srch   <= 1'b0;
      r_rd_oob    <= 1'b0;
      r_disp_hold <= '0;
      r_srch_hold <= '0;
    end else begin
      r_rd_disp <= w_disp_gnt;
      r_rd_srch <= w_srch_gnt && !srch_we;
      r_rd_oob  <= w_oob;
      if (r_rd_disp) r_disp_hold <= w_rd_val;
      if (r_rd_srch) r_srch_hold <= w_rd_val;
      if (w_srch_gnt || w_load_gnt) r_rr_load <= !r_rr_load;

      if (r_state == ST_CLEAR) begin
        if (r_clr_addr == LAST_ADDR) begin
          r_state    <= ST_RUN;
          r_clr_addr <= '0;
        end else begin
          r_clr_addr <= r_clr_addr + 1'b1;
        end
      end else if (clear_start) begin
        r_state    <= ST_CLEAR;
        r_clr_addr <= '0;
        r_oob_err  <= 1'b0;
      end else if (w_any_gnt && w_oob) begin
        r_oob_err <= 1'b1;
      end
    end
  end

  assign clear_busy  = w_clearing || !reset;
  assign disp_gnt    = w_disp_gnt;
  assign srch_gnt    = w_srch_gnt;
  assign load_gnt    = w_load_gnt;
  assign disp_rvalid = r_rd_disp;
  assign srch_rvalid = r_rd_srch;
  assign disp_rdata  = r_rd_disp ? w_rd_val : r_disp_hold;
  assign srch_rdata  = r_rd_srch ? w_rd_val : r_srch_hold;
  assign oob_err     = r_oob_err;

endmodule
